// File: rtl/regfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  function automatic int rf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Depth must be a power of two so every address maps onto a real entry.
  function automatic bit rf_params_ok(input int xlen, input int nregs,
                                      input int nread, input int nwrite);
    return (xlen >= 1) && (nregs >= 2) && ((nregs & (nregs - 1)) == 0) &&
           (nread >= 1) && (nwrite >= 1);
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then reports ready.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = !reset;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) state_d = READY;
      end
      READY: ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read/M-write register file with optional zero register,
// write-to-read bypass, same-address write conflict flag and post-reset clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 2,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][XLEN-1:0]   rd,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NWRITE-1:0][XLEN-1:0]  wd,
  output logic                         ready,
  output logic                         wr_conflict
);

  generate
    if (!rf_params_ok(XLEN, NREGS, NREAD, NWRITE)) begin : g_bad_params
      $error("regfile_mp: illegal parameter combination");
    end
  endgenerate

  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic            wr_act;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wr_conflict_q, wr_conflict_d;

  regfile_clear_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign wr_act = ready & ~reset;

  // Ascending port order lets the highest-index port win on address clashes.
  always_comb begin
    rf_d = rf_q;
    if (clr_en) rf_d[clr_addr] = '0;
    if (wr_act) begin
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && !((ZERO_REG0 != 0) && (wa[p] == '0))) rf_d[wa[p]] = wd[p];
      end
    end
  end

  // Register-0 writes still count here even though they are discarded above.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int p = 0; p < NWRITE; p++) begin
      for (int q = p + 1; q < NWRITE; q++) begin
        if (we[p] && we[q] && (wa[p] == wa[q])) wr_conflict_d = 1'b1;
      end
    end
    if (!wr_act) wr_conflict_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_conflict_q <= 1'b0;
    else       wr_conflict_q <= wr_conflict_d;
  end

  assign wr_conflict = wr_conflict_q;

  // Zero rule is applied last so it overrides both storage and bypass.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd[i] = rf_q[ra[i]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWRITE; p++) begin
          if (we[p] && (wa[p] == ra[i])) rd[i] = wd[p];
        end
      end
      if (!ready || ((ZERO_REG0 != 0) && (ra[i] == '0))) rd[i] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register files (zero-reg+bypass, and plain) with shared stimulus
// and compares both against an array-based reference every cycle.
module tb_regfile_mp;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NREAD-1:0][AW-1:0]    ra;
  logic [NWRITE-1:0]           we;
  logic [NWRITE-1:0][AW-1:0]   wa;
  logic [NWRITE-1:0][XLEN-1:0] wd;
  logic [NREAD-1:0][XLEN-1:0]  rd_a, rd_b;
  logic                        ready_a, ready_b, conf_a, conf_b;

  initial forever #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
               .ZERO_REG0(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_a), .we(we), .wa(wa), .wd(wd),
    .ready(ready_a), .wr_conflict(conf_a));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
               .ZERO_REG0(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .we(we), .wa(wa), .wd(wd),
    .ready(ready_b), .wr_conflict(conf_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the file contents as plain arrays, plus edges since reset.
  logic [XLEN-1:0] mem_a [NREGS];
  logic [XLEN-1:0] mem_b [NREGS];
  int  since_rst = 0;
  bit  model_on  = 1'b0;
  bit  conf_m    = 1'b0;

  function automatic logic [XLEN-1:0] exp_rd(input int i, input bit is_a);
    logic [XLEN-1:0] v;
    if (is_a) v = mem_a[ra[i]];
    else      v = mem_b[ra[i]];
    if (is_a) begin
      for (int p = 0; p < NWRITE; p++)
        if (we[p] && wa[p] == ra[i]) v = wd[p];
      if (ra[i] == 0) v = '0;
    end
    if (since_rst < NREGS) v = '0;
    return v;
  endfunction

  task automatic model_step();
    if (reset) begin
      model_on  = 1'b1;
      since_rst = 0;
      conf_m    = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        mem_a[r] = '0;
        mem_b[r] = '0;
      end
    end else if (model_on) begin
      conf_m = 1'b0;
      if (since_rst < NREGS) begin
        since_rst++;
      end else begin
        for (int p = 0; p < NWRITE; p++)
          for (int q = p + 1; q < NWRITE; q++)
            if (we[p] && we[q] && wa[p] == wa[q]) conf_m = 1'b1;
        for (int p = 0; p < NWRITE; p++) begin
          if (we[p]) begin
            mem_b[wa[p]] = wd[p];
            if (wa[p] != 0) mem_a[wa[p]] = wd[p];
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("ready_a", ready_a, since_rst >= NREGS);
      chk("ready_b", ready_b, since_rst >= NREGS);
      chk("conf_a", conf_a, conf_m);
      chk("conf_b", conf_b, conf_m);
      for (int i = 0; i < NREAD; i++) begin
        chk($sformatf("rd_a[%0d]", i), rd_a[i], exp_rd(i, 1'b1));
        chk($sformatf("rd_b[%0d]", i), rd_b[i], exp_rd(i, 1'b0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = '0; wa = '0; wd = '0; ra = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Clear phase: ready rises on the 32nd edge; a write in the middle is lost.
    for (int k = 1; k <= NREGS; k++) begin
      cyc();
      we = (k == 9) ? 2'b01 : 2'b00;
      wa[0] = 5'd5;
      wd[0] = 64'hDEAD;
      ra[0] = AW'($urandom_range(0, NREGS - 1));
      ra[1] = AW'($urandom_range(0, NREGS - 1));
      @(negedge clk);
      chk("clear_ready", ready_a, (k == NREGS));
      chk("clear_rd", rd_a[0], 64'h0);
    end

    for (int r = 0; r < NREGS; r++) begin
      cyc();
      we = '0;
      ra[0] = AW'(r);
      ra[1] = AW'(r);
      @(negedge clk);
      chk("post_clear_a", rd_a[1], 64'h0);
      chk("post_clear_b", rd_b[0], 64'h0);
    end
    cyc(); ra[0] = 5'd5;
    @(negedge clk);
    chk("r5_dropped", rd_b[0], 64'h0);

    // Same-address write on both ports.
    cyc(); we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 64'h11; wd[1] = 64'h22;
    ra[0] = 5'd3; ra[1] = 5'd3;
    @(negedge clk);
    chk("conflict_bypass_a", rd_a[0], 64'h22);
    chk("conflict_old_b", rd_b[0], 64'h0);
    cyc(); we = '0;
    @(negedge clk);
    chk("conflict_r3_a", rd_a[0], 64'h22);
    chk("conflict_r3_b", rd_b[1], 64'h22);
    chk("conflict_pulse", conf_a, 1'b1);
    cyc();
    @(negedge clk);
    chk("conflict_clear", conf_a, 1'b0);

    // Bypass versus registered read.
    cyc(); we = 2'b01; wa[0] = 5'd7; wd[0] = 64'hAB; ra[1] = 5'd7;
    @(negedge clk);
    chk("bypass_same_a", rd_a[1], 64'hAB);
    chk("bypass_old_b", rd_b[1], 64'h0);
    cyc(); we = '0;
    @(negedge clk);
    chk("bypass_next_a", rd_a[1], 64'hAB);
    chk("bypass_next_b", rd_b[1], 64'hAB);

    // Register 0 handling.
    cyc(); we = 2'b01; wa[0] = 5'd0; wd[0] = 64'hFF; ra[0] = 5'd0;
    @(negedge clk);
    chk("r0_same_a", rd_a[0], 64'h0);
    cyc(); we = '0;
    @(negedge clk);
    chk("r0_next_a", rd_a[0], 64'h0);
    chk("r0_next_b", rd_b[0], 64'hFF);

    // Random traffic with narrow address range to provoke clashes.
    for (int n = 0; n < 400; n++) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      we = NWRITE'($urandom_range(0, 3));
      for (int p = 0; p < NWRITE; p++) begin
        wa[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS - 1));
        wd[p] = {$urandom, $urandom};
      end
      for (int i = 0; i < NREAD; i++)
        ra[i] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS - 1));
    end
    cyc(); reset = 1'b0; we = '0;
    repeat (NREGS + 1) cyc();
    @(negedge clk);
    chk("ready_after_random", ready_a, 1'b1);

    // Reset while READY with live data in r9.
    cyc(); we = 2'b10; wa[1] = 5'd9; wd[1] = 64'h55;
    cyc(); we = '0; ra[0] = 5'd9; ra[1] = 5'd9;
    @(negedge clk);
    chk("r9_written", rd_a[0], 64'h55);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("reset_ready_drop", ready_a, 1'b0);
    for (int k = 1; k <= NREGS; k++) begin
      cyc();
      we = (k == 4) ? 2'b01 : 2'b00;
      wa[0] = 5'd9;
      wd[0] = 64'h77;
      @(negedge clk);
      chk("reclear_r9", rd_b[0], 64'h0);
      chk("reclear_ready", ready_b, (k == NREGS));
    end
    cyc(); we = '0;
    @(negedge clk);
    chk("r9_after_a", rd_a[0], 64'h0);
    chk("r9_after_b", rd_b[1], 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
